// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, pipeline type codes and IR field positions.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } type_e;

  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  // Codes 6 and 7 are undefined and behave as HALT.
  function automatic type_e decode_type(input logic [2:0] code);
    if (code > 3'd5) return HALT;
    return type_e'(code);
  endfunction

endpackage

// File: rtl/mips32_dmem.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module mips32_dmem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] DMEM [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) DMEM[addr_i] <= wdata_i;
  end

  assign rdata_o = DMEM[addr_i];

endmodule

// File: rtl/mips32_mem_wb.sv
// MIPS32 MEM and WB stages with internal DMEM and sticky HALTED flag.
// Optional MIPS32_MEMWB_STATS_EN adds a saturating retired_count output.
module mips32_mem_wb
  import mips32_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned DMEM_AW    = 10
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic [2:0]  ex_mem_type,
  input  logic [31:0] ex_mem_ir,
  input  logic [31:0] ex_mem_aluout,
  input  logic [31:0] ex_mem_b,
  input  logic        taken_branch,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
`ifdef MIPS32_MEMWB_STATS_EN
  output logic [31:0] retired_count,
`endif
  output logic        halted
);

  type_e              ex_type;
  logic               freeze;
  logic               retire;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_rdata;

  logic               mem_wb_valid_q, mem_wb_valid_d;
  type_e              mem_wb_type_q,  mem_wb_type_d;
  logic [31:0]        mem_wb_ir_q,    mem_wb_ir_d;
  logic [31:0]        mem_wb_alu_q,   mem_wb_alu_d;
  logic [31:0]        mem_wb_lmd_q,   mem_wb_lmd_d;

  logic               wb_we_q,   wb_we_d;
  logic [4:0]         wb_addr_q, wb_addr_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               halted_q,  halted_d;

  logic [4:0]         rd_field;
  logic [4:0]         rt_field;

  assign ex_type = decode_type(ex_mem_type);

  // A HALT sitting in WB blocks the following bundle too, so nothing presented
  // on the edge where halted rises can touch DMEM or the MEM_WB registers.
  assign freeze    = halted_q || (mem_wb_valid_q && (mem_wb_type_q == HALT));
  assign retire    = mem_wb_valid_q && !halted_q;
  assign dmem_addr = ex_mem_aluout[DMEM_AW-1:0];
  assign dmem_we   = ex_mem_valid && !freeze && (ex_type == STORE) && !taken_branch;

  mips32_dmem #(
    .DEPTH (DMEM_DEPTH),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clk_i   (clk1),
    .we_i    (dmem_we),
    .addr_i  (dmem_addr),
    .wdata_i (ex_mem_b),
    .rdata_o (dmem_rdata)
  );

  // MEM stage; a bubble clears mem_wb_valid so WB never retires a bundle twice.
  always_comb begin
    mem_wb_valid_d = mem_wb_valid_q;
    mem_wb_type_d  = mem_wb_type_q;
    mem_wb_ir_d    = mem_wb_ir_q;
    mem_wb_alu_d   = mem_wb_alu_q;
    mem_wb_lmd_d   = mem_wb_lmd_q;
    if (!freeze) begin
      if (ex_mem_valid) begin
        mem_wb_ir_d    = ex_mem_ir;
        mem_wb_type_d  = ex_type;
        mem_wb_alu_d   = ex_mem_aluout;
        mem_wb_valid_d = !taken_branch || (ex_type == HALT);
        if (ex_type == LOAD) mem_wb_lmd_d = dmem_rdata;
      end else begin
        mem_wb_valid_d = 1'b0;
      end
    end
  end

  assign rd_field = mem_wb_ir_q[RD_MSB:RD_LSB];
  assign rt_field = mem_wb_ir_q[RT_MSB:RT_LSB];

  always_comb begin
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    halted_d  = halted_q;
    if (retire) begin
      case (mem_wb_type_q)
        RR_ALU: if (rd_field != '0) begin
          wb_we_d   = 1'b1;
          wb_addr_d = rd_field;
          wb_data_d = mem_wb_alu_q;
        end
        RM_ALU: if (rt_field != '0) begin
          wb_we_d   = 1'b1;
          wb_addr_d = rt_field;
          wb_data_d = mem_wb_alu_q;
        end
        LOAD: if (rt_field != '0) begin
          wb_we_d   = 1'b1;
          wb_addr_d = rt_field;
          wb_data_d = mem_wb_lmd_q;
        end
        HALT:    halted_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      mem_wb_valid_q <= 1'b0;
      mem_wb_type_q  <= RR_ALU;
      mem_wb_ir_q    <= '0;
      mem_wb_alu_q   <= '0;
      mem_wb_lmd_q   <= '0;
      wb_we_q        <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      halted_q       <= 1'b0;
    end else begin
      mem_wb_valid_q <= mem_wb_valid_d;
      mem_wb_type_q  <= mem_wb_type_d;
      mem_wb_ir_q    <= mem_wb_ir_d;
      mem_wb_alu_q   <= mem_wb_alu_d;
      mem_wb_lmd_q   <= mem_wb_lmd_d;
      wb_we_q        <= wb_we_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      halted_q       <= halted_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign halted  = halted_q;

`ifdef MIPS32_MEMWB_STATS_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != '1)) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk1) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{ex_mem_aluout[31:DMEM_AW], mem_wb_ir_q[31:21], mem_wb_ir_q[10:0]};

endmodule

// File: tb/tb_mips32_mem_wb.sv
// Scoreboard bench for mips32_mem_wb: expected register writes are queued at issue
// and matched against every wb_we pulse; DMEM and halt behaviour checked inline.
module tb_mips32_mem_wb;
  import mips32_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  logic [2:0]  ex_mem_type;
  logic [31:0] ex_mem_ir;
  logic [31:0] ex_mem_aluout;
  logic [31:0] ex_mem_b;
  logic        taken_branch;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        halted;
`ifdef MIPS32_MEMWB_STATS_EN
  logic [31:0] retired_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  mips32_mem_wb #(.DMEM_DEPTH(1024), .DMEM_AW(10)) dut (
    .clk1          (clk1),
    .rst           (rst),
    .ex_mem_valid  (ex_mem_valid),
    .ex_mem_type   (ex_mem_type),
    .ex_mem_ir     (ex_mem_ir),
    .ex_mem_aluout (ex_mem_aluout),
    .ex_mem_b      (ex_mem_b),
    .taken_branch  (taken_branch),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
`ifdef MIPS32_MEMWB_STATS_EN
    .retired_count (retired_count),
`endif
    .halted        (halted)
  );

  always #5 clk1 = ~clk1;

  // Scoreboard consumer: every write pulse must match the oldest queued write.
  always @(negedge clk1) begin
    if (wb_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write addr=%0d data=%0d, required no write", wb_addr, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_addr, wb_data} !== mon_e) begin
          errors++;
          $display("FAIL wb_write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   wb_addr, wb_data, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] rm(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic issue(input logic [2:0] t, input logic [31:0] ir, input logic [31:0] alu,
                       input logic [31:0] bv, input logic tb_f);
    @(negedge clk1);
    ex_mem_valid  = 1'b1;
    ex_mem_type   = t;
    ex_mem_ir     = ir;
    ex_mem_aluout = alu;
    ex_mem_b      = bv;
    taken_branch  = tb_f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk1);
      ex_mem_valid = 1'b0;
      taken_branch = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    ex_mem_valid = 1'b0;
    taken_branch = 1'b0;
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic drain_check(input string name);
    idle(3);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d writes never appeared, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_mem_valid = 1'b0; ex_mem_type = 3'd0; ex_mem_ir = '0;
    ex_mem_aluout = '0; ex_mem_b = '0; taken_branch = 1'b0;
    repeat (2) @(negedge clk1);
    checks += 4;
    if (wb_we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b, required 0", wb_we); end
    if (wb_addr !== 5'd0)  begin errors++; $display("FAIL reset_addr: got %0d, required 0", wb_addr); end
    if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h, required 0", wb_data); end
    if (halted !== 1'b0)   begin errors++; $display("FAIL reset_halted: got %b, required 0", halted); end
`ifdef MIPS32_MEMWB_STATS_EN
    checks++;
    if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d, required 0", retired_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_alu();
    issue(RM_ALU, rm(OP_ADDI, 5'd0, 5'd1, 16'd10), 32'd10, '0, 1'b0);
    exp_q.push_back({5'd1, 32'd10});
    issue(RR_ALU, rr(OP_ADD, 5'd2, 5'd3, 5'd5), 32'h1234_5678, '0, 1'b0);
    exp_q.push_back({5'd5, 32'h1234_5678});
    drain_check("alu");
  endtask

  task automatic test_store_load();
    dut.u_dmem.DMEM[120] = 32'd0;
    dut.u_dmem.DMEM[7]   = 32'd0;
    issue(STORE, rm(OP_SW, 5'd0, 5'd2, 16'd120), 32'd120, 32'd85, 1'b0);
    issue(LOAD, rm(OP_LW, 5'd0, 5'd3, 16'd120), 32'd120, '0, 1'b0);
    exp_q.push_back({5'd3, 32'd85});
    issue(STORE, rm(OP_SW, 5'd0, 5'd2, 16'd0), 32'd1031, 32'hABCD, 1'b0);
    issue(LOAD, rm(OP_LW, 5'd0, 5'd8, 16'd7), 32'd7, '0, 1'b0);
    exp_q.push_back({5'd8, 32'hABCD});
    drain_check("store_load");
    checks += 2;
    if (dut.u_dmem.DMEM[120] !== 32'd85) begin
      errors++; $display("FAIL dmem_store: got %0d, required 85", dut.u_dmem.DMEM[120]);
    end
    if (dut.u_dmem.DMEM[7] !== 32'hABCD) begin
      errors++; $display("FAIL dmem_wrap: got %0h, required abcd", dut.u_dmem.DMEM[7]);
    end
  endtask

  task automatic test_squash();
    dut.u_dmem.DMEM[5] = 32'h55;
    issue(STORE, rm(OP_SW, 5'd0, 5'd2, 16'd5), 32'd5, 32'd7, 1'b1);
    issue(RR_ALU, rr(OP_SUB, 5'd1, 5'd2, 5'd6), 32'd66, '0, 1'b1);
    idle(1);
    @(negedge clk1);
    checks += 2;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL squash_we: got %b, required 0", wb_we); end
    if (dut.u_dmem.DMEM[5] !== 32'h55) begin
      errors++; $display("FAIL squash_store: got %0h, required 55", dut.u_dmem.DMEM[5]);
    end
    drain_check("squash");
  endtask

  task automatic test_r0();
    issue(RM_ALU, rm(OP_ADDI, 5'd0, 5'd9, 16'd77), 32'd77, '0, 1'b0);
    exp_q.push_back({5'd9, 32'd77});
    issue(RR_ALU, rr(OP_ADD, 5'd1, 5'd2, 5'd0), 32'd99, '0, 1'b0);
    idle(1);
    @(negedge clk1);
    checks += 3;
    if (wb_we !== 1'b0)    begin errors++; $display("FAIL r0_we: got %b, required 0", wb_we); end
    if (wb_addr !== 5'd9)  begin errors++; $display("FAIL r0_addr_hold: got %0d, required 9", wb_addr); end
    if (wb_data !== 32'd77) begin errors++; $display("FAIL r0_data_hold: got %0d, required 77", wb_data); end
    drain_check("r0");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [4:0]  r;
      logic [31:0] v;
      r = 5'(10 + i);
      v = $urandom;
      if (i % 2 == 0) issue(RR_ALU, rr(OP_OR, 5'd1, 5'd2, r), v, '0, 1'b0);
      else            issue(RM_ALU, rm(OP_SLTI, 5'd1, r, 16'd3), v, '0, 1'b0);
      exp_q.push_back({r, v});
    end
    drain_check("b2b");
  endtask

  task automatic test_reset_priority();
    issue(RM_ALU, rm(OP_ADDI, 5'd0, 5'd2, 16'd3), 32'd3, '0, 1'b0);
    @(negedge clk1);
    rst = 1'b1;
    ex_mem_valid = 1'b0;
    @(negedge clk1);
    rst = 1'b0;
    checks += 2;
    if (wb_we !== 1'b0)   begin errors++; $display("FAIL rst_prio_we: got %b, required 0", wb_we); end
    if (wb_addr !== 5'd0) begin errors++; $display("FAIL rst_prio_addr: got %0d, required 0", wb_addr); end
    drain_check("rst_prio");
  endtask

  task automatic test_halt();
    dut.u_dmem.DMEM[9] = 32'h99;
    issue(HALT, {OP_HLT, 26'd0}, '0, '0, 1'b0);
    issue(STORE, rm(OP_SW, 5'd0, 5'd2, 16'd9), 32'd9, 32'd1, 1'b0);
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b, required 0", halted); end
    issue(RR_ALU, rr(OP_ADD, 5'd1, 5'd2, 5'd4), 32'd44, '0, 1'b0);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_rise: got %b, required 1", halted); end
    issue(STORE, rm(OP_SW, 5'd0, 5'd2, 16'd9), 32'd9, 32'd2, 1'b0);
    drain_check("halt");
    checks += 2;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b, required 1", halted); end
    if (dut.u_dmem.DMEM[9] !== 32'h99) begin
      errors++; $display("FAIL halt_store: got %0h, required 99", dut.u_dmem.DMEM[9]);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b, required 0", halted); end
    issue(3'd7, 32'd0, '0, '0, 1'b0);
    idle(2);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_unknown: got %b, required 1", halted); end
    do_reset();
  endtask

`ifdef MIPS32_MEMWB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(RR_ALU, rr(OP_MUL, 5'd1, 5'd2, 5'(20 + i)), 32'(100 + i), '0, 1'b0);
      exp_q.push_back({5'(20 + i), 32'(100 + i)});
    end
    issue(RR_ALU, rr(OP_AND, 5'd1, 5'd2, 5'd25), 32'd5, '0, 1'b1);
    issue(HALT, {OP_HLT, 26'd0}, '0, '0, 1'b0);
    drain_check("stats");
    checks++;
    if (retired_count !== 32'd4) begin
      errors++; $display("FAIL stats_count: got %0d, required 4", retired_count);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_squash();
    test_r0();
    test_back_to_back();
    test_reset_priority();
    test_halt();
`ifdef MIPS32_MEMWB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
